// File: rtl/obstacle_gap_gen.sv
// Multi-channel random gap-height generator for scrolling obstacles.
//
// Each channel raises respawn_req when its obstacle leaves the screen. The
// request is latched into a pending bit, granted round-robin, and served by
// a four-state FSM. The FSM takes 16 bits from a free-running Galois LFSR and
// scales them into [Y_MIN, Y_MIN+Y_RANGE-1] by multiply-and-shift. It can
// optionally slew-limit the result against the channel's previous height.
// Finally it commits the height and pulses that channel's ack for one cycle.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous active-high reset
//   freeze       pause: LFSR and FSM hold, request capture continues
//   seed_load    load the LFSR from seed (SEED if seed is zero)
//   seed         LFSR seed value
//   respawn_req  per-channel request, level sampled every edge
//   respawn_ack  per-channel one-cycle pulse when that gap_y updates
//   gap_y        packed heights, channel i at [i*OUT_W +: OUT_W]
//   busy         FSM not idle or a request still pending
module obstacle_gap_gen #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned OUT_W    = 9,
    parameter int unsigned Y_MIN    = 40,
    parameter int unsigned Y_RANGE  = 320,
    parameter int unsigned MAX_STEP = 0,
    parameter logic [31:0] SEED     = 32'hACE1_2468
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  freeze,
    input  logic                  seed_load,
    input  logic [31:0]           seed,
    input  logic [N_CH-1:0]       respawn_req,
    output logic [N_CH-1:0]       respawn_ack,
    output logic [N_CH*OUT_W-1:0] gap_y,
    output logic                  busy
);

    localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PW    = 16 + OUT_W + 1;
    // Two spare bits so prev+MAX_STEP and cand+MAX_STEP cannot overflow.
    localparam int unsigned CW    = OUT_W + 2;
    localparam logic [OUT_W-1:0] Y_MID = OUT_W'(Y_MIN + Y_RANGE / 2);
    localparam logic [31:0]      POLY  = 32'h8020_0003;

    typedef enum logic [1:0] {StIdle, StDraw, StScale, StCommit} state_e;

    state_e                state_q, state_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic [N_CH-1:0]       pend_q, pend_d;
    logic [N_CH-1:0]       pend_clr;
    logic [N_CH-1:0]       ack_q, ack_d;
    logic [PTR_W-1:0]      rr_q, rr_d;
    logic [PTR_W-1:0]      sel_q, sel_d;
    logic [15:0]           r_q, r_d;
    logic [PW-1:0]         prod_q, prod_d;
    logic [OUT_W-1:0]      res_q, res_d;
    logic [N_CH*OUT_W-1:0] gap_q, gap_d;

    // The low 16 product bits are the fractional part and are discarded.
    logic unused_prod_frac;
    assign unused_prod_frac = ^prod_q[15:0];

    // LFSR: load has priority and works while frozen.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = (seed == 32'h0) ? SEED : seed;
        end else if (!freeze) begin
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
        end
    end

    // Round-robin grant. The loop runs downward so the lowest matching index
    // wins. hi_* finds the first pending bit at or above rr_q, and lo_* finds
    // the first pending bit overall, which is used for the wrap-around case.
    logic             hi_vld, lo_vld;
    logic [PTR_W-1:0] hi_idx, lo_idx;
    logic             grant_vld;
    logic [PTR_W-1:0] grant_idx;

    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                lo_vld = 1'b1;
                lo_idx = PTR_W'(i);
                if (PTR_W'(i) >= rr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = PTR_W'(i);
                end
            end
        end
        grant_vld = lo_vld;
        grant_idx = hi_vld ? hi_idx : lo_idx;
    end

    // Scale and optional slew clamp. prev is always in range, so the clamped
    // value stays in range as well.
    logic [OUT_W-1:0] prev_gap;
    logic [CW-1:0]    cand, prev, step, clamped;

    always_comb begin
        prev_gap = gap_q[OUT_W-1:0];
        for (int i = 0; i < int'(N_CH); i++) begin
            if (sel_q == PTR_W'(i)) begin
                prev_gap = gap_q[i*OUT_W +: OUT_W];
            end
        end
        cand    = CW'(Y_MIN) + CW'(prod_q[PW-1:16]);
        prev    = CW'(prev_gap);
        step    = CW'(MAX_STEP);
        clamped = cand;
        if (MAX_STEP > 0) begin
            if (cand > prev + step) begin
                clamped = prev + step;
            end else if (cand + step < prev) begin
                clamped = prev - step;
            end
        end
    end

    // FSM next state and datapath registers.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        r_d      = r_q;
        prod_d   = prod_q;
        res_d    = res_q;
        gap_d    = gap_q;
        ack_d    = ack_q;
        rr_d     = rr_q;
        pend_clr = '0;
        if (!freeze) begin
            ack_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (grant_vld) begin
                        sel_d   = grant_idx;
                        r_d     = lfsr_q[15:0];
                        state_d = StDraw;
                    end
                end
                StDraw: begin
                    prod_d  = PW'(r_q) * PW'(Y_RANGE);
                    state_d = StScale;
                end
                StScale: begin
                    res_d   = clamped[OUT_W-1:0];
                    state_d = StCommit;
                end
                StCommit: begin
                    for (int i = 0; i < int'(N_CH); i++) begin
                        if (sel_q == PTR_W'(i)) begin
                            gap_d[i*OUT_W +: OUT_W] = res_q;
                            ack_d[i]                = 1'b1;
                            pend_clr[i]             = 1'b1;
                        end
                    end
                    rr_d    = (sel_q == PTR_W'(N_CH - 1)) ? '0 : sel_q + PTR_W'(1);
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
        // A new request on the same edge as the clear keeps the bit set.
        pend_d = (pend_q & ~pend_clr) | respawn_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            pend_q  <= '0;
            ack_q   <= '0;
            rr_q    <= '0;
            sel_q   <= '0;
            r_q     <= '0;
            prod_q  <= '0;
            res_q   <= '0;
            gap_q   <= {N_CH{Y_MID}};
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            r_q     <= r_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
            gap_q   <= gap_d;
        end
    end

    assign respawn_ack = ack_q;
    assign gap_y       = gap_q;
    assign busy        = (state_q != StIdle) || (pend_q != '0);

endmodule

// File: tb/tb_obstacle_gap_gen.sv
// Testbench for obstacle_gap_gen.
// Two instances share the same stimulus: one has no slew limit and the other
// has MAX_STEP=16. Both are compared on every cycle against a
// transaction-level model. Directed checks pin the model with hand-computed
// values, and a randomized phase then exercises the block.
module tb_obstacle_gap_gen;

    localparam int          Y_MIN   = 40;
    localparam int          Y_RANGE = 320;
    localparam int          Y_MID   = Y_MIN + Y_RANGE / 2;
    localparam logic [31:0] SEED    = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        freeze = 1'b0;
    logic        seed_load = 1'b0;
    logic [31:0] seed = 32'h0;
    logic [1:0]  req = 2'b00;

    logic [1:0]  ack_a, ack_b;
    logic [17:0] gy_a, gy_b;
    logic        busy_a, busy_b;

    always #5 clk = ~clk;

    obstacle_gap_gen #(.MAX_STEP(0)) u_dut0 (
        .clk         (clk),
        .reset       (reset),
        .freeze      (freeze),
        .seed_load   (seed_load),
        .seed        (seed),
        .respawn_req (req),
        .respawn_ack (ack_a),
        .gap_y       (gy_a),
        .busy        (busy_a)
    );

    obstacle_gap_gen #(.MAX_STEP(16)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .freeze      (freeze),
        .seed_load   (seed_load),
        .seed        (seed),
        .respawn_req (req),
        .respawn_ack (ack_b),
        .gap_y       (gy_b),
        .busy        (busy_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic        s_reset, s_freeze, s_seed_load;
    logic [31:0] s_seed;
    logic [1:0]  s_req;
    always @(posedge clk) begin
        s_reset     <= reset;
        s_freeze    <= freeze;
        s_seed_load <= seed_load;
        s_seed      <= seed;
        s_req       <= req;
    end

    // Behavioural model: a granted draw commits on the third unfrozen edge
    // after the grant. Index d selects the instance (0: no slew, 1: step 16).
    logic [31:0] m_lfsr;
    logic [1:0]  m_pend [2];
    logic [1:0]  m_ack  [2];
    int          m_cnt  [2];
    int          m_sel  [2];
    int          m_res  [2];
    int          m_rr   [2];
    int          m_gap  [2][2];

    function automatic int draw(input logic [15:0] r, input int prev, input int ms);
        int c;
        c = Y_MIN + ((int'(r) * Y_RANGE) >> 16);
        if (ms > 0) begin
            if (c > prev + ms) c = prev + ms;
            else if (c + ms < prev) c = prev - ms;
        end
        return c;
    endfunction

    task automatic model_edge();
        logic [1:0] np;
        bit         found;
        int         idx;
        if (s_reset) begin
            m_lfsr = SEED;
            for (int d = 0; d < 2; d++) begin
                m_pend[d] = 2'b00; m_ack[d] = 2'b00; m_cnt[d] = 0;
                m_sel[d] = 0; m_res[d] = 0; m_rr[d] = 0;
                m_gap[d][0] = Y_MID; m_gap[d][1] = Y_MID;
            end
            return;
        end
        for (int d = 0; d < 2; d++) begin
            np = m_pend[d] | s_req;
            if (!s_freeze) begin
                m_ack[d] = 2'b00;
                if (m_cnt[d] == 0) begin
                    if (m_pend[d] != 2'b00) begin
                        found = 1'b0;
                        for (int k = 0; k < 2; k++) begin
                            idx = (m_rr[d] + k) % 2;
                            if (!found && m_pend[d][idx]) begin
                                found = 1'b1;
                                m_sel[d] = idx;
                            end
                        end
                        m_res[d] = draw(m_lfsr[15:0], m_gap[d][m_sel[d]], (d == 1) ? 16 : 0);
                        m_cnt[d] = 3;
                    end
                end else begin
                    if (m_cnt[d] == 1) begin
                        m_gap[d][m_sel[d]] = m_res[d];
                        m_ack[d][m_sel[d]] = 1'b1;
                        np = m_pend[d];
                        np[m_sel[d]] = 1'b0;
                        np = np | s_req;
                        m_rr[d] = (m_sel[d] + 1) % 2;
                    end
                    m_cnt[d] = m_cnt[d] - 1;
                end
            end
            m_pend[d] = np;
        end
        if (s_seed_load) m_lfsr = (s_seed == 32'h0) ? SEED : s_seed;
        else if (!s_freeze) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
    endtask

    // Per-cycle compare plus slew/range monitor on channel 0.
    int       prev_s = Y_MID;
    int       n_ack0 = 0;
    int       mn = 1000;
    int       mx = 0;
    bit       rnd = 1'b0;
    logic [1:0] ack_a_d = 2'b00;
    logic [1:0] ack_b_d = 2'b00;

    initial begin
        int nv, df;
        forever begin
            @(negedge clk);
            model_edge();
            chk("ack_a", ack_a, m_ack[0]);
            chk("ack_b", ack_b, m_ack[1]);
            chk("gap_a", gy_a, {9'(m_gap[0][1]), 9'(m_gap[0][0])});
            chk("gap_b", gy_b, {9'(m_gap[1][1]), 9'(m_gap[1][0])});
            chk("busy_a", busy_a, (m_cnt[0] != 0) || (m_pend[0] != 2'b00));
            chk("busy_b", busy_b, (m_cnt[1] != 0) || (m_pend[1] != 2'b00));
            chk("lfsr", u_dut0.lfsr_q, m_lfsr);
            if (s_reset) begin
                prev_s = Y_MID;
            end else begin
                if (ack_b[0] && !ack_b_d[0]) begin
                    nv = int'(gy_b[8:0]);
                    df = (nv > prev_s) ? nv - prev_s : prev_s - nv;
                    if (df > 16) $display("FAIL slew_step: prev %0d new %0d", prev_s, nv);
                    chk("slew_le16", df <= 16, 1);
                    chk("range_b", (nv >= Y_MIN) && (nv <= Y_MIN + Y_RANGE - 1), 1);
                    prev_s = nv;
                    n_ack0++;
                end
                if (ack_a[0] && !ack_a_d[0]) begin
                    nv = int'(gy_a[8:0]);
                    chk("range_a", (nv >= Y_MIN) && (nv <= Y_MIN + Y_RANGE - 1), 1);
                    if (rnd) begin
                        if (nv < mn) mn = nv;
                        if (nv > mx) mx = nv;
                    end
                end
            end
            ack_a_d = ack_a;
            ack_b_d = ack_b;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ack(input int ch, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ack_a[ch] && n < budget);
    endtask

    initial begin
        int n, extra;
        // Reset values.
        reset = 1'b1;
        repeat (3) step();
        chk("rst_gap_a", gy_a, {9'd200, 9'd200});
        chk("rst_gap_b", gy_b, {9'd200, 9'd200});
        chk("rst_ack", ack_a, 2'b00);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_lfsr", u_dut0.lfsr_q, 32'hACE1_2468);
        reset = 1'b0;
        step();

        // seed=1 with req0 on the same edge: r=1 gives 40 (slew: 200-16).
        seed_load = 1'b1; seed = 32'h1; req = 2'b01;
        step();
        seed_load = 1'b0; seed = 32'h0; req = 2'b00;
        repeat (3) step();
        chk("lat_e3_ack", ack_a, 2'b00);
        step();
        chk("lat_e4_ack", ack_a, 2'b01);
        chk("seed1_gap0", gy_a[8:0], 9'd40);
        chk("seed1_gap1", gy_a[17:9], 9'd200);
        chk("seed1_slew", gy_b[8:0], 9'd184);
        step();
        chk("lat_e5_ack", ack_a, 2'b00);
        chk("lat_e5_busy", busy_a, 1'b0);

        // r=0xFFFF gives the top of the range (slew: 184+16).
        seed_load = 1'b1; seed = 32'h0000_FFFF; req = 2'b01;
        step();
        seed_load = 1'b0; seed = 32'h0; req = 2'b00;
        wait_ack(0, 20, n);
        chk("max_lat", n, 4);
        chk("max_gap0", gy_a[8:0], 9'd359);
        chk("max_slew", gy_b[8:0], 9'd200);
        repeat (2) step();

        // Zero seed falls back to SEED.
        seed_load = 1'b1; seed = 32'h0;
        step();
        seed_load = 1'b0;
        chk("seed0_lfsr", u_dut0.lfsr_q, 32'hACE1_2468);

        // Reset while in SCALE discards the draw.
        req = 2'b01;
        step();
        req = 2'b00;
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("midrst_ack", ack_a, 2'b00);
        chk("midrst_gap", gy_a, {9'd200, 9'd200});
        chk("midrst_busy", busy_a, 1'b0);
        reset = 1'b0;
        step();
        chk("midrst_noack", ack_a, 2'b00);
        step();

        // Contention twice in a row: ch0 then ch1 each time.
        for (int rep = 0; rep < 2; rep++) begin
            req = 2'b11;
            step();
            req = 2'b00;
            wait_ack(0, 20, n);
            chk("cont_ch0", n, 4);
            wait_ack(1, 20, n);
            chk("cont_ch1", n, 4);
        end
        repeat (2) step();

        // Freeze for ten edges with a second req1 merged in.
        req = 2'b10;
        step();
        req = 2'b00;
        step();
        freeze = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req = (i == 3) ? 2'b10 : 2'b00;
            step();
        end
        freeze = 1'b0; req = 2'b00;
        wait_ack(1, 20, n);
        chk("frz_lat", n, 3);
        extra = 0;
        repeat (10) begin
            step();
            if (ack_a[1]) extra++;
        end
        chk("frz_merge", extra, 0);

        // Randomized phase.
        n_ack0 = 0;
        rnd = 1'b1;
        for (int c = 0; c < 20000 && n_ack0 < 200; c++) begin
            req       = 2'($urandom_range(0, 3));
            freeze    = ($urandom_range(0, 9) == 0);
            seed_load = ($urandom_range(0, 199) == 0);
            seed      = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
            step();
        end
        req = 2'b00; freeze = 1'b0; seed_load = 1'b0;
        repeat (8) step();
        rnd = 1'b0;
        chk("rnd_acks200", n_ack0 >= 200, 1);
        chk("rnd_min_lt60", mn < 60, 1);
        chk("rnd_max_gt340", mx > 340, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
